asp_irq_ctrl: RTL and testbench
===============================

Name: asp_irq_ctrl

Overview:
- Parametrised interrupt aggregator for the ASP. Generalises the fixed DMA_0/kernel/DMA_1 interrupt bit assignment to N sources.
- Each source has its own level/edge mode, sticky pending, mask and software-force bits. All of these are visible over a 64-bit AVMM CSR slave on the MMIO64 path.
- Drives the per-line host interrupt vector plus a combined line. Includes a re-assertion holdoff to throttle interrupt storms.

Parameters:
- NUM_IRQ_LINES, 4, width of host interrupt vector; lines >= NUM_IRQ_USED tied 0.
- NUM_IRQ_USED, 3, number of active sources (1..NUM_IRQ_LINES); bit 0 DMA_0, bit 1 kernel, bit 2 DMA_1 by convention.
- EDGE_MODE_DEFAULT, 'b101, reset value of MODE register (1 = edge, 0 = level).
- HOLDOFF_CYCLES, 16, minimum cycles irq_any stays low after falling; 0 disables holdoff.
- CSR_ADDR_WIDTH, 3, AVMM word address width (64-bit words).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous active-low reset.
- irq_in  in  NUM_IRQ_USED  raw interrupt sources, synchronous to clk.
- avs_address  in  CSR_ADDR_WIDTH  CSR word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  64  write data.
- avs_byteenable  in  8  byte enables; a write applies only to enabled bytes.
- avs_readdata  out  64  read data.
- avs_readdatavalid  out  1  read response strobe.
- avs_waitrequest  out  1  tied 0.
- irq_out  out  NUM_IRQ_LINES  masked pending vector to host.
- irq_any  out  1  OR of irq_out.

Behaviour:
- Reset (reset_n low at a rising edge):
  - pending, force, irq_out, irq_any, avs_readdatavalid, avs_readdata and holdoff counter all reset to 0.
  - MASK resets to all-ones in the used bits. MODE resets to EDGE_MODE_DEFAULT.
  - The input pipeline regs irq_q and irq_q2 reset to 0, so an input already high at reset release registers as an edge.
- Input sampling: irq_q <= irq_in; irq_q2 <= irq_q. Edge event = irq_q & ~irq_q2.
- Pending bit i, edge mode:
  - Set on edge event or on a FORCE write with bit i set.
  - Cleared by a W1C write to PENDING bit i.
  - If a set and a clear occur in the same cycle, set wins.
- Pending bit i, level mode:
  - pending[i] <= irq_q[i] | force_set[i]. A force in level mode is a one-cycle pulse.
  - W1C is ignored.
- MODE change: pending bit i is cleared in the same cycle MODE bit i is written (either direction).
- Output stage:
  - irq_out[i] <= pending[i] & mask[i] & ~holdoff_active, registered.
  - irq_any = |irq_out, combinational from registered irq_out.
- Latency: irq_in high at edge T gives pending at T+2, then irq_out/irq_any at T+3.
- Holdoff:
  - On the cycle irq_any transitions 1 -> 0, load counter with HOLDOFF_CYCLES.
  - holdoff_active = (counter != 0). Counter decrements each cycle to 0.
  - Pending continues to accumulate during holdoff.
- CSR map (word addresses; unused bits read 0, writes to them ignored):
  - 0 STATUS, RO: irq_q.
  - 1 PENDING, RW1C.
  - 2 MASK, RW.
  - 3 MODE, RW.
  - 4 FORCE, W1S (write-only pulse), reads 0.
  - 5 INFO, RO: [7:0] NUM_IRQ_LINES, [15:8] NUM_IRQ_USED, [31:16] HOLDOFF_CYCLES.
  - 6,7: read 0.
- CSR timing:
  - Read: avs_readdatavalid asserted exactly 1 cycle after avs_read, with data sampled at the read cycle.
  - Read and write in the same cycle: the write commits and the read returns pre-write data.
  - Read of PENDING concurrent with a set returns the pre-set value.

Test Plan:
- Reset, then read INFO -> 0x0010_0304 (defaults); MASK reads 0x7; MODE reads 0x5; irq_out = 0.
- Pulse irq_in[0] high for 1 cycle at T -> irq_out = 4'b0001 at T+3 and held. Write PENDING = 0x1 -> irq_out = 0 two cycles later. irq_any stays low for 16 cycles even if irq_in[2] pulses at fall+1; irq_out[2] rises at fall+17.
- irq_in[1] (level) held high -> irq_out[1] = 1 at T+3. A W1C to PENDING has no effect. irq_in[1] low -> irq_out[1] = 0 three cycles later.
- MASK = 0x6, pulse irq_in[0] -> PENDING reads 0x1 and irq_out[0] = 0. Write MASK = 0x7 -> irq_out[0] = 1 within 2 cycles.
- W1C of PENDING bit 2 in the same cycle as an edge event on source 2 -> PENDING bit 2 remains 1.
- FORCE = 0x4 -> PENDING bit 2 set, irq_out[2] = 1. Deassert reset_n mid-holdoff -> all outputs 0 and counter 0 next cycle.

Source files
------------

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt aggregator: per-source edge/level capture, mask, software force,
// re-assertion holdoff, and a 64-bit AVMM CSR slave.
module asp_irq_ctrl #(
    parameter int NUM_IRQ_LINES     = 4,
    parameter int NUM_IRQ_USED      = 3,
    parameter int EDGE_MODE_DEFAULT = 'b101,
    parameter int HOLDOFF_CYCLES    = 16,
    parameter int CSR_ADDR_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ_USED-1:0]   irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0] avs_address,
    input  logic                      avs_read,
    input  logic                      avs_write,
    input  logic [63:0]               avs_writedata,
    input  logic [7:0]                avs_byteenable,
    output logic [63:0]               avs_readdata,
    output logic                      avs_readdatavalid,
    output logic                      avs_waitrequest,
    output logic [NUM_IRQ_LINES-1:0]  irq_out,
    output logic                      irq_any
);

    localparam int U = NUM_IRQ_USED;
    localparam logic [U-1:0] MODE_RST = U'(EDGE_MODE_DEFAULT);
    localparam logic [15:0]  HOLD     = 16'(HOLDOFF_CYCLES);
    localparam logic [63:0]  INFO     = {32'd0, HOLD, 8'(NUM_IRQ_USED), 8'(NUM_IRQ_LINES)};

    localparam logic [CSR_ADDR_WIDTH-1:0] A_STATUS  = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_PENDING = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MASK    = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MODE    = CSR_ADDR_WIDTH'(3);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_FORCE   = CSR_ADDR_WIDTH'(4);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_INFO    = CSR_ADDR_WIDTH'(5);

    logic [U-1:0] irq_q, irq_q2, pending, mask, mode, irq_out_r;
    logic [U-1:0] edge_evt, wr_en_bits, wr_bits, w1c, force_set, mode_clr;
    logic [U-1:0] pending_nxt, mask_nxt, mode_nxt, out_nxt;
    logic [63:0]  be_mask, rd_mux;
    logic [15:0]  hold_cnt;
    logic         holdoff_active, falling;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            be_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
        end
    end

    assign wr_en_bits = be_mask[U-1:0];
    assign wr_bits    = avs_writedata[U-1:0] & wr_en_bits;
    assign edge_evt   = irq_q & ~irq_q2;

    always_comb begin
        w1c       = '0;
        force_set = '0;
        mode_clr  = '0;
        mask_nxt  = mask;
        mode_nxt  = mode;
        if (avs_write) begin
            case (avs_address)
                A_PENDING: w1c       = wr_bits;
                A_FORCE:   force_set = wr_bits;
                A_MASK:    mask_nxt  = (mask & ~wr_en_bits) | wr_bits;
                A_MODE: begin
                    mode_nxt = (mode & ~wr_en_bits) | wr_bits;
                    mode_clr = wr_en_bits;
                end
                default: ;
            endcase
        end
    end

    // Edge sources are sticky with set beating W1C; level sources simply track
    // the sampled input. Any MODE write to a bit discards its pending state.
    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < U; i++) begin
            if (mode_clr[i]) begin
                pending_nxt[i] = 1'b0;
            end else if (mode[i]) begin
                pending_nxt[i] = edge_evt[i] | force_set[i] | (pending[i] & ~w1c[i]);
            end else begin
                pending_nxt[i] = irq_q[i] | force_set[i];
            end
        end
    end

    assign holdoff_active = (hold_cnt != 16'd0);
    assign out_nxt        = pending & mask & ~{U{holdoff_active}};
    assign falling        = (|irq_out_r) && (out_nxt == '0);

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_STATUS:  rd_mux = 64'(irq_q);
            A_PENDING: rd_mux = 64'(pending);
            A_MASK:    rd_mux = 64'(mask);
            A_MODE:    rd_mux = 64'(mode);
            A_INFO:    rd_mux = INFO;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q             <= '0;
            irq_q2            <= '0;
            pending           <= '0;
            mask              <= '1;
            mode              <= MODE_RST;
            irq_out_r         <= '0;
            hold_cnt          <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            irq_q             <= irq_in;
            irq_q2            <= irq_q;
            pending           <= pending_nxt;
            mask              <= mask_nxt;
            mode              <= mode_nxt;
            irq_out_r         <= out_nxt;
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
            // The counter is armed on the same edge the outputs drop, so the
            // quiet window starts with the first low cycle of irq_any.
            if (falling && (HOLD != 16'd0)) begin
                hold_cnt <= HOLD;
            end else if (holdoff_active) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        irq_out        = '0;
        irq_out[U-1:0] = irq_out_r;
    end

    assign irq_any         = |irq_out_r;
    assign avs_waitrequest = 1'b0;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural reference model.
module tb_asp_irq_ctrl;

    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  irq_in;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [3:0]  irq_out;
    logic        irq_any;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [2:0]  m_q1, m_q2, m_pend, m_mask, m_mode;
    logic [3:0]  m_out;
    int          m_quiet;
    logic        m_rdv;
    logic [63:0] m_rd;

    asp_irq_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .irq_out           (irq_out),
        .irq_any           (irq_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] regValue(input logic [2:0] a);
        case (a)
            3'd0:    return 64'(m_q1);
            3'd1:    return 64'(m_pend);
            3'd2:    return 64'(m_mask);
            3'd3:    return 64'(m_mode);
            3'd5:    return (64'(HOLD) << 16) | (64'd3 << 8) | 64'd4;
            default: return 64'd0;
        endcase
    endfunction

    // Advances the model by one rising edge using the inputs presented to the DUT.
    task automatic modelStep();
        logic [2:0] np, wd;
        logic [3:0] nout;
        logic       wpend, wforce, wmode;
        if (!reset_n) begin
            m_q1 = '0; m_q2 = '0; m_pend = '0; m_mask = 3'b111; m_mode = 3'b101;
            m_out = '0; m_quiet = 0; m_rdv = 1'b0; m_rd = '0;
            return;
        end
        m_rdv = avs_read;
        if (avs_read) m_rd = regValue(avs_address);
        wd     = avs_writedata[2:0] & {3{avs_byteenable[0]}};
        wpend  = avs_write && avs_address == 3'd1;
        wforce = avs_write && avs_address == 3'd4;
        wmode  = avs_write && avs_address == 3'd3 && avs_byteenable[0];
        for (int i = 0; i < 3; i++) begin
            logic f;
            f = wforce && wd[i];
            if (wmode) np[i] = 1'b0;
            else if (m_mode[i]) np[i] = (m_q1[i] && !m_q2[i]) || f || (m_pend[i] && !(wpend && wd[i]));
            else np[i] = m_q1[i] || f;
        end
        nout = (m_quiet > 0) ? 4'b0000 : {1'b0, m_pend & m_mask};
        if (m_out != 4'b0 && nout == 4'b0) m_quiet = HOLD;
        else if (m_quiet > 0) m_quiet--;
        m_out = nout;
        m_pend = np;
        if (avs_write && avs_address == 3'd2 && avs_byteenable[0]) m_mask = avs_writedata[2:0];
        if (wmode) m_mode = avs_writedata[2:0];
        m_q2 = m_q1;
        m_q1 = irq_in;
    endtask

    task automatic checkOutput();
        chk("irq_out", 64'(irq_out), 64'(m_out));
        chk("irq_any", 64'(irq_any), 64'(|m_out));
        chk("rdvalid", 64'(avs_readdatavalid), 64'(m_rdv));
        chk("rddata", avs_readdata, m_rd);
        chk("waitreq", 64'(avs_waitrequest), 64'd0);
    endtask

    // One clock with the currently driven inputs; outputs checked 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic csrWrite(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        applyStimulus();
        avs_write = 1'b0;
    endtask

    task automatic csrRead(input logic [2:0] a, output logic [63:0] d);
        avs_address = a; avs_read = 1'b1;
        applyStimulus();
        avs_read = 1'b0;
        applyStimulus();
        d = avs_readdata;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    initial begin
        logic [63:0] d;
        int n;
        reset_n = 1'b0; irq_in = '0; avs_address = '0; avs_read = 1'b0;
        avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
        idle(3);
        reset_n = 1'b1;
        chk("reset_irq_out", 64'(irq_out), 64'd0);

        csrRead(3'd5, d); chk("info", d, 64'h0000_0000_0010_0304);
        csrRead(3'd2, d); chk("mask_reset", d, 64'h7);
        csrRead(3'd3, d); chk("mode_reset", d, 64'h5);

        // Edge source 0: pulse, latency, hold, then W1C and holdoff on source 2
        irq_in = 3'b001; applyStimulus(); irq_in = 3'b000;
        idle(2);
        chk("edge0_latency", 64'(irq_out), 64'h1);
        idle(3);
        chk("edge0_held", 64'(irq_out), 64'h1);
        csrWrite(3'd1, 64'h1, 8'hff);
        applyStimulus();
        chk("edge0_cleared", 64'(irq_out), 64'h0);
        irq_in = 3'b100; applyStimulus(); n = 1; irq_in = 3'b000;
        while (!irq_out[2] && n < 40) begin
            applyStimulus();
            n++;
        end
        chk("holdoff_rise", 64'(n), 64'd17);
        csrWrite(3'd1, 64'h4, 8'hff);
        idle(20);

        // Level source 1
        irq_in = 3'b010; idle(3);
        chk("level1_on", 64'(irq_out), 64'h2);
        csrWrite(3'd1, 64'h2, 8'hff);
        chk("level1_w1c_ignored", 64'(irq_out), 64'h2);
        irq_in = 3'b000; idle(3);
        chk("level1_off", 64'(irq_out), 64'h0);
        idle(20);

        // Masking
        csrWrite(3'd2, 64'h6, 8'hff);
        irq_in = 3'b001; applyStimulus(); irq_in = 3'b000;
        idle(3);
        csrRead(3'd1, d); chk("masked_pending", d, 64'h1);
        chk("masked_out", 64'(irq_out), 64'h0);
        csrWrite(3'd2, 64'h7, 8'hff);
        applyStimulus();
        chk("unmask_out", 64'(irq_out), 64'h1);
        csrWrite(3'd1, 64'h1, 8'hff);
        idle(20);

        // W1C colliding with an edge event: set wins
        irq_in = 3'b100; applyStimulus(); irq_in = 3'b000;
        csrWrite(3'd1, 64'h4, 8'hff);
        csrRead(3'd1, d); chk("set_beats_w1c", 64'(d[2]), 64'd1);
        csrWrite(3'd1, 64'h4, 8'hff);
        idle(20);

        // Force, then reset in the middle of the holdoff window
        csrWrite(3'd4, 64'h4, 8'hff);
        applyStimulus();
        chk("force_out", 64'(irq_out), 64'h4);
        csrRead(3'd4, d); chk("force_reads0", d, 64'h0);
        csrWrite(3'd1, 64'h4, 8'hff);
        idle(4);
        reset_n = 1'b0; applyStimulus();
        chk("rst_irq_out", 64'(irq_out), 64'h0);
        chk("rst_irq_any", 64'(irq_any), 64'h0);
        chk("rst_holdoff", 64'(dut.hold_cnt), 64'h0);
        reset_n = 1'b1;
        idle(2);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            end
            r = int'($urandom_range(0, 99));
            avs_read = ($urandom_range(0, 4) == 0);
            avs_write = 1'b0;
            avs_address = 3'($urandom_range(0, 7));
            if (r < 20) begin
                avs_write = 1'b1;
                avs_writedata = {$urandom, $urandom};
                avs_byteenable = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
                if (r < 2) avs_address = 3'd3;
                else avs_address = 3'($urandom_range(1, 4));
                if (avs_address == 3'd3 && r >= 2) avs_address = 3'd1;
            end
            applyStimulus();
        end
        avs_read = 1'b0; avs_write = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
